// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/op_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register.
module op_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set,
    input  logic [REG_ADDR_W-1:0] i_set_idx,
    input  logic                  i_clr,
    input  logic [REG_ADDR_W-1:0] i_clr_idx,
    input  logic [REG_ADDR_W-1:0] i_src_a,
    input  logic [REG_ADDR_W-1:0] i_src_b,
    input  logic [REG_ADDR_W-1:0] i_dst,
    output logic                  o_busy_a,
    output logic                  o_busy_b,
    output logic                  o_busy_d
);
    import mips_pkg::*;

    localparam int unsigned NReg = 2 ** REG_ADDR_W;

    logic [NReg-1:0] r_busy;
    logic [NReg-1:0] w_busy_next;

    // Next busy vector: clear first so a same-index set (new producer) wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr) begin
            w_busy_next[i_clr_idx] = 1'b0;
        end
        if (i_set) begin
            w_busy_next[i_set_idx] = 1'b1;
        end
        w_busy_next[REG_ZERO] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy_a = r_busy[i_src_a];
    assign o_busy_b = r_busy[i_src_b];
    assign o_busy_d = r_busy[i_dst];

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: operand fetch with writeback bypass, scoreboard stalls
// and a valid/ready output register toward execute.
module operand_fetch #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_we,
    output logic [REG_ADDR_W-1:0] rA,
    output logic [REG_ADDR_W-1:0] rB,
    input  logic [DATA_W-1:0]     aData,
    input  logic [DATA_W-1:0]     bData,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dR,
    input  logic [DATA_W-1:0]     wb_wData,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_we,
    output logic [PERF_W-1:0]     perf_stalls
);
    import mips_pkg::*;

    localparam logic [REG_ADDR_W-1:0] Zero = REG_ADDR_W'(REG_ZERO);

    logic                  r_ex_valid;
    logic [DATA_W-1:0]     r_ex_a;
    logic [DATA_W-1:0]     r_ex_b;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_we;
    logic [PERF_W-1:0]     r_perf;

    logic              w_busy_a, w_busy_b, w_busy_d;
    logic              w_byp_a, w_byp_b, w_byp_d;
    logic              w_rdy_a, w_rdy_b, w_waw;
    logic              w_hazard, w_slot_free, w_issue;
    logic              w_set, w_clr;
    logic [DATA_W-1:0] w_val_a, w_val_b;

    assign rA = in_rs;
    assign rB = in_rt;

    // Writeback data bypass: RegFile only commits at the edge.
    always_comb begin
        w_byp_a = wb_valid && (wb_dR == in_rs);
        w_byp_b = wb_valid && (wb_dR == in_rt);
        w_byp_d = wb_valid && (wb_dR == in_rd);
        w_val_a = aData;
        w_val_b = bData;
        if (in_rs == Zero) begin
            w_val_a = '0;
        end else if (w_byp_a) begin
            w_val_a = wb_wData;
        end
        if (in_rt == Zero) begin
            w_val_b = '0;
        end else if (w_byp_b) begin
            w_val_b = wb_wData;
        end
    end

    // RAW/WAW hazard detection and input handshake.
    always_comb begin
        w_rdy_a     = (in_rs == Zero) || !w_busy_a || w_byp_a;
        w_rdy_b     = (in_rt == Zero) || !w_busy_b || w_byp_b;
        w_waw       = in_we && (in_rd != Zero) && w_busy_d && !w_byp_d;
        w_hazard    = in_valid && (!w_rdy_a || !w_rdy_b || w_waw);
        w_slot_free = !r_ex_valid || ex_ready;
        in_ready    = w_slot_free && !w_hazard;
        w_issue     = in_valid && in_ready;
        w_set       = w_issue && in_we && (in_rd != Zero);
        w_clr       = wb_valid && (wb_dR != Zero);
    end

    op_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set     (w_set),
        .i_set_idx (in_rd),
        .i_clr     (w_clr),
        .i_clr_idx (wb_dR),
        .i_src_a   (in_rs),
        .i_src_b   (in_rt),
        .i_dst     (in_rd),
        .o_busy_a  (w_busy_a),
        .o_busy_b  (w_busy_b),
        .o_busy_d  (w_busy_d)
    );

    // Output register toward execute; data holds when the slot drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_rd    <= '0;
            r_ex_we    <= 1'b0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_a     <= w_val_a;
            r_ex_b     <= w_val_b;
            r_ex_rd    <= in_rd;
            r_ex_we    <= in_we;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // Saturating hazard-stall counter; backpressure-only cycles are not hazards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_hazard && (r_perf != {PERF_W{1'b1}})) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_a        = r_ex_a;
    assign ex_b        = r_ex_b;
    assign ex_rd       = r_ex_rd;
    assign ex_we       = r_ex_we;
    assign perf_stalls = r_perf;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural RegFile and a
// pending-set reference model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_we;
    logic [4:0]  in_rs, in_rt, in_rd, rA, rB;
    logic [31:0] aData, bData;
    logic        wb_valid;
    logic [4:0]  wb_dR;
    logic [31:0] wb_wData;
    logic        ex_valid, ex_ready, ex_we;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_rd;
    logic [15:0] perf_stalls;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    operand_fetch #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .PERF_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .rA          (rA),
        .rB          (rB),
        .aData       (aData),
        .bData       (bData),
        .wb_valid    (wb_valid),
        .wb_dR       (wb_dR),
        .wb_wData    (wb_wData),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .perf_stalls (perf_stalls)
    );

    // Behavioural RegFile: combinational read, write at the edge, $0 reads 0.
    logic [31:0] rf [32];
    logic        rf_load;
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h01010101 * i;
        end else if (wb_valid && wb_dR != 0) begin
            rf[wb_dR] <= wb_wData;
        end
    end
    assign aData = (rA == 0) ? 32'h0 : rf[rA];
    assign bData = (rB == 0) ? 32'h0 : rf[rB];

    // Reference model state.
    bit          pend [32];
    bit          m_ev;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    bit          m_we;
    int          m_perf;

    function automatic bit bypassed(logic [4:0] s);
        return wb_valid && wb_dR == s;
    endfunction

    function automatic bit src_ok(logic [4:0] s);
        return s == 0 || !pend[s] || bypassed(s);
    endfunction

    function automatic logic [31:0] src_val(logic [4:0] s);
        if (s == 0) return 32'h0;
        if (bypassed(s)) return wb_wData;
        return rf[s];
    endfunction

    function automatic bit m_hazard();
        bit dst_blocked;
        dst_blocked = in_we && in_rd != 0 && pend[in_rd] && !bypassed(in_rd);
        return in_valid && (!src_ok(in_rs) || !src_ok(in_rt) || dst_blocked);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input int rd, input bit we);
        in_valid = v;
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_we    = we;
    endtask

    task automatic set_wb(input bit v, input int d, input logic [31:0] data);
        wb_valid = v;
        wb_dR    = 5'(d);
        wb_wData = data;
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic step();
        bit          hz, rdy, iss;
        logic [31:0] na, nb;
        #1;
        hz  = m_hazard();
        rdy = (!m_ev || ex_ready) && !hz;
        iss = in_valid && rdy;
        na  = src_val(in_rs);
        nb  = src_val(in_rt);
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("rA", 32'(rA), 32'(in_rs));
        check("rB", 32'(rB), 32'(in_rt));
        if (rst) begin
            m_ev = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0; m_perf = 0;
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else begin
            if (iss) begin
                m_ev = 1; m_a = na; m_b = nb; m_rd = in_rd; m_we = in_we;
            end else if (ex_ready) begin
                m_ev = 0;
            end
            if (hz && m_perf < 65535) m_perf++;
            if (wb_valid && wb_dR != 0) pend[wb_dR] = 0;
            if (iss && in_we && in_rd != 0) pend[in_rd] = 1;
        end
        @(posedge clk);
        #1;
        check("ex_valid", 32'(ex_valid), 32'(m_ev));
        check("ex_a", ex_a, m_a);
        check("ex_b", ex_b, m_b);
        check("ex_rd", 32'(ex_rd), 32'(m_rd));
        check("ex_we", 32'(ex_we), 32'(m_we));
        check("perf_stalls", 32'(perf_stalls), 32'(m_perf));
    endtask

    typedef struct {
        int          rs, rt;
        bit          wbv;
        int          wbd;
        logic [31:0] wbdata;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs [7];
    int   p0;
    int   pq [$];

    initial begin
        vecs[0] = '{1,  2,  0, 0,  32'h0,        32'h01010101, 32'h02020202};
        vecs[1] = '{0,  3,  0, 0,  32'h0,        32'h00000000, 32'h03030303};
        vecs[2] = '{3,  3,  1, 3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3] = '{3,  0,  0, 0,  32'h0,        32'hDEADBEEF, 32'h00000000};
        vecs[4] = '{0,  0,  1, 0,  32'h11111111, 32'h00000000, 32'h00000000};
        vecs[5] = '{31, 16, 1, 16, 32'hCAFEF00D, 32'h1F1F1F1F, 32'hCAFEF00D};
        vecs[6] = '{16, 31, 0, 0,  32'h0,        32'hCAFEF00D, 32'h1F1F1F1F};

        rst = 1; rf_load = 1; ex_ready = 1;
        set_in(0, 0, 0, 0, 0);
        set_wb(0, 0, 32'h0);
        step();
        rf_load = 0;
        step();
        rst = 0;
        check("reset ex_valid", 32'(ex_valid), 32'h0);
        check("reset perf", 32'(perf_stalls), 32'h0);

        // Single-cycle operand-select vectors.
        foreach (vecs[i]) begin
            set_in(1, vecs[i].rs, vecs[i].rt, 0, 0);
            set_wb(vecs[i].wbv, vecs[i].wbd, vecs[i].wbdata);
            #1 check("vec in_ready", 32'(in_ready), 32'h1);
            step();
            check("vec ex_a", ex_a, vecs[i].exp_a);
            check("vec ex_b", ex_b, vecs[i].exp_b);
        end
        set_wb(0, 0, 32'h0);

        // 1: reset, write $4, read it back.
        rst = 1; set_in(0, 0, 0, 0, 0); step(); rst = 0;
        set_wb(1, 4, 32'hFFFFFFFF); step(); set_wb(0, 0, 32'h0);
        set_in(1, 4, 1, 0, 0); step();
        check("t1 ex_a", ex_a, 32'hFFFFFFFF);
        check("t1 ex_b", ex_b, 32'h01010101);

        // 2: same-cycle bypass.
        set_wb(1, 4, 32'h12345678);
        #1 check("t2 in_ready", 32'(in_ready), 32'h1);
        step(); set_wb(0, 0, 32'h0);
        check("t2 ex_a", ex_a, 32'h12345678);

        // 3: RAW stall, then release by writeback.
        set_in(1, 0, 0, 5, 1); step();
        set_in(1, 5, 0, 0, 0);
        #1 check("t3 stall", 32'(in_ready), 32'h0);
        p0 = int'(perf_stalls);
        step();
        check("t3 perf", 32'(perf_stalls), 32'(p0 + 1));
        set_wb(1, 5, 32'hA5A5A5A5);
        #1 check("t3 release", 32'(in_ready), 32'h1);
        step(); set_wb(0, 0, 32'h0);
        check("t3 ex_a", ex_a, 32'hA5A5A5A5);
        #1 check("t3 busy5 clear", 32'(in_ready), 32'h1);
        step();

        // 4: $0 destination never tracked.
        set_in(1, 0, 0, 0, 1); step();
        set_in(1, 0, 0, 0, 0);
        #1 check("t4 in_ready", 32'(in_ready), 32'h1);
        step();
        check("t4 ex_a", ex_a, 32'h0);
        check("t4 ex_b", ex_b, 32'h0);

        // 5: backpressure holds outputs, no stall counting.
        set_in(1, 1, 2, 0, 0); step();
        ex_ready = 0;
        set_in(1, 2, 1, 0, 0);
        p0 = int'(perf_stalls);
        for (int k = 0; k < 3; k++) begin
            #1 check("t5 in_ready", 32'(in_ready), 32'h0);
            step();
            check("t5 ex_a stable", ex_a, 32'h01010101);
            check("t5 ex_valid", 32'(ex_valid), 32'h1);
            check("t5 perf", 32'(perf_stalls), 32'(p0));
        end
        ex_ready = 1;
        #1 check("t5 release", 32'(in_ready), 32'h1);
        step();
        check("t5 ex_a", ex_a, 32'h02020202);

        // 6: WAW stall, then reset while busy[7] is set.
        set_in(1, 0, 0, 7, 1); step();
        #1 check("t6 waw stall", 32'(in_ready), 32'h0);
        step(); step();
        set_wb(1, 7, 32'h00000077);
        #1 check("t6 waw release", 32'(in_ready), 32'h1);
        step(); set_wb(0, 0, 32'h0);
        set_in(1, 7, 0, 0, 0);
        #1 check("t6 busy7 set wins", 32'(in_ready), 32'h0);
        rst = 1; step(); rst = 0;
        check("t6 rst ex_valid", 32'(ex_valid), 32'h0);
        check("t6 rst perf", 32'(perf_stalls), 32'h0);
        #1 check("t6 busy cleared", 32'(in_ready), 32'h1);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            ex_ready = $urandom_range(0, 3) != 0;
            rst      = $urandom_range(0, 299) == 0;
            pq.delete();
            for (int i = 1; i < 32; i++) if (pend[i]) pq.push_back(i);
            if ($urandom_range(0, 2) == 0) begin
                if (pq.size() > 0 && $urandom_range(0, 3) != 0)
                    set_wb(1, pq[$urandom_range(0, pq.size() - 1)], $urandom);
                else
                    set_wb(1, $urandom_range(0, 7), $urandom);
            end else begin
                set_wb(0, 0, 32'h0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
